// File: rtl/alu32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu32_pkg                                              |
// | Description : Opcodes, flag bit positions and the opcode enum shared |
// |               by the ALU core and the ALU register stage.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu32_pkg;

    // Opcode encodings (5-bit ALUControl values)
    localparam logic [4:0] c_op_mov = 5'b00101;
    localparam logic [4:0] c_op_add = 5'b00110;
    localparam logic [4:0] c_op_sub = 5'b00111;
    localparam logic [4:0] c_op_mul = 5'b01000;
    localparam logic [4:0] c_op_div = 5'b01001;
    localparam logic [4:0] c_op_and = 5'b01010;
    localparam logic [4:0] c_op_or  = 5'b01011;
    localparam logic [4:0] c_op_shl = 5'b01100;
    localparam logic [4:0] c_op_shr = 5'b01101;
    localparam logic [4:0] c_op_cmp = 5'b01110;

    // Bit positions inside the {E, V, N, Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_E = 3;

    // Flag vector reported for illegal operations (E only)
    localparam logic [3:0] c_flags_err = 4'b1000;

    typedef enum logic [4:0] {
        OP_MOV = 5'b00101,
        OP_ADD = 5'b00110,
        OP_SUB = 5'b00111,
        OP_MUL = 5'b01000,
        OP_DIV = 5'b01001,
        OP_AND = 5'b01010,
        OP_OR  = 5'b01011,
        OP_SHL = 5'b01100,
        OP_SHR = 5'b01101,
        OP_CMP = 5'b01110
    } alu_op_e;

endpackage : alu32_pkg
`default_nettype wire

// File: rtl/alu32_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu32_core                                             |
// | Description : Purely combinational ALU datapath. Produces the next   |
// |               result and {E,V,N,Z} flags from the operands, opcode   |
// |               and the currently held result (CMP keeps it).          |
// |               MUL/DIV exist only when ALU32_MULDIV_EN is defined;    |
// |               otherwise those opcodes fall into the error path.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu32_core
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] data1,
    input  logic signed [WIDTH-1:0] data2,
    input  logic        [4:0]       ALUControl,
    input  logic signed [WIDTH-1:0] cur_result,
    output logic signed [WIDTH-1:0] next_result,
    output logic        [3:0]       next_flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;
    logic                    w_add_ovf;
    logic                    w_sub_ovf;
    logic                    w_shift_big;
    logic        [WIDTH-1:0] w_shl;
    logic        [WIDTH-1:0] w_shr;

    assign w_sum  = data1 + data2;
    assign w_diff = data1 - data2;

    // Overflow when operand signs make the result sign impossible
    assign w_add_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1]  != data1[WIDTH-1]);
    assign w_sub_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_diff[WIDTH-1] != data1[WIDTH-1]);

    // Any set bit above the shift-index field means amount >= WIDTH
    assign w_shift_big = |data2[WIDTH-1:SHW];
    assign w_shl       = $unsigned(data1) << data2[SHW-1:0];
    assign w_shr       = $unsigned(data1) >> data2[SHW-1:0];

`ifdef ALU32_MULDIV_EN
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic                      w_mul_ovf;
    logic signed [WIDTH-1:0]   w_quot;
    logic                      w_div_ovf;

    assign w_a_ext   = {{WIDTH{data1[WIDTH-1]}}, data1};
    assign w_b_ext   = {{WIDTH{data2[WIDTH-1]}}, data2};
    assign w_prod    = w_a_ext * w_b_ext;
    // Product fits only if the upper half is a pure sign extension of bit WIDTH-1
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){w_prod[WIDTH-1]}});
    assign w_div_ovf = (data1 == c_min_neg) && (data2 == {WIDTH{1'b1}});
    // Operands forced safe on the cases handled separately below
    assign w_quot    = (data2 == '0 || w_div_ovf) ? '0 : data1 / data2;
`endif

    logic signed [WIDTH-1:0] w_res;
    logic                    w_v;
    logic                    w_err;
    logic                    w_cmp;

    // Opcode decode: select the datapath result and the overflow condition
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_err = 1'b0;
        w_cmp = 1'b0;
        case (ALUControl)
            c_op_mov: w_res = data1;
            c_op_add: begin
                w_res = w_sum;
                w_v   = w_add_ovf;
            end
            c_op_sub: begin
                w_res = w_diff;
                w_v   = w_sub_ovf;
            end
`ifdef ALU32_MULDIV_EN
            c_op_mul: begin
                w_res = w_prod[WIDTH-1:0];
                w_v   = w_mul_ovf;
            end
            c_op_div: begin
                if (data2 == '0) begin
                    w_err = 1'b1;
                end else if (w_div_ovf) begin
                    w_res = c_min_neg;
                    w_v   = 1'b1;
                end else begin
                    w_res = w_quot;
                end
            end
`endif
            c_op_and: w_res = data1 & data2;
            c_op_or:  w_res = data1 | data2;
            c_op_shl: w_res = w_shift_big ? '0 : w_shl;
            c_op_shr: w_res = w_shift_big ? '0 : w_shr;
            c_op_cmp: w_cmp = 1'b1;
            default:  w_err = 1'b1;
        endcase
    end

    // Final result/flag formation: error, compare, or ordinary result flags
    always_comb begin
        next_result = '0;
        next_flags  = '0;
        if (w_err) begin
            next_flags = c_flags_err;
        end else if (w_cmp) begin
            next_result        = cur_result;
            next_flags[FLAG_Z] = (data1 == data2);
            next_flags[FLAG_N] = (data1 < data2);
        end else begin
            next_result        = w_res;
            next_flags[FLAG_Z] = (w_res == '0);
            next_flags[FLAG_N] = w_res[WIDTH-1];
            next_flags[FLAG_V] = w_v;
        end
    end

endmodule : alu32_core
`default_nettype wire

// File: rtl/alu32_bits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu32_bits                                             |
// | Description : Registered 32-bit ALU. One operation accepted every    |
// |               cycle; result and flags appear one cycle later.        |
// |               Optional MUL/DIV enabled by macro ALU32_MULDIV_EN.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu32_bits
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data1,
    input  logic signed [WIDTH-1:0] data2,
    input  logic        [4:0]       ALUControl,
    output logic signed [WIDTH-1:0] ALUResult,
    output logic                    zero,
    output logic        [3:0]       RFlags
);

    logic signed [WIDTH-1:0] w_next_result;
    logic        [3:0]       w_next_flags;
    logic signed [WIDTH-1:0] r_result;
    logic        [3:0]       r_flags;
    logic                    r_zero;

    alu32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .data1       (data1),
        .data2       (data2),
        .ALUControl  (ALUControl),
        .cur_result  (r_result),
        .next_result (w_next_result),
        .next_flags  (w_next_flags)
    );

    // Output registers; reset clears them immediately and discards in-flight work
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_result <= w_next_result;
            r_flags  <= w_next_flags;
            r_zero   <= w_next_flags[FLAG_Z];
        end
    end

    assign ALUResult = r_result;
    assign RFlags    = r_flags;
    assign zero      = r_zero;

endmodule : alu32_bits
`default_nettype wire

// File: tb/tb_alu32_bits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu32_bits                                          |
// | Description : Scoreboard bench for alu32_bits. Expected values are   |
// |               queued at issue; a monitor pops them one cycle later.  |
// |               Expectations follow ALU32_MULDIV_EN when defined.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu32_bits;

    logic               clk;
    logic               reset;
    logic signed [31:0] data1;
    logic signed [31:0] data2;
    logic        [4:0]  ALUControl;
    logic signed [31:0] ALUResult;
    logic               zero;
    logic        [3:0]  RFlags;

    alu32_bits #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data1      (data1),
        .data2      (data2),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .zero       (zero),
        .RFlags     (RFlags)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        vld   = 1'b0;
    logic [31:0] q_res[$];
    logic [3:0]  q_flg[$];
    string       q_nm[$];

    // Clock: first rising edge at 10 ns, period 10 ns
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input string nm);
        @(negedge clk);
        ALUControl = op;
        data1      = a;
        data2      = b;
        q_res.push_back(er);
        q_flg.push_back(ef);
        q_nm.push_back(nm);
        vld = 1'b1;
    endtask

    // Monitor: an operation valid at a rising edge is checked 1 ns later
    initial begin : monitor
        logic        take;
        logic [31:0] er;
        logic [3:0]  ef;
        string       nm;
        forever begin
            @(posedge clk);
            take = vld;
            #1;
            if (take) begin
                if (q_res.size() == 0) begin
                    check("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    er = q_res.pop_front();
                    ef = q_flg.pop_front();
                    nm = q_nm.pop_front();
                    check({nm, "_result"}, ALUResult, er);
                    check({nm, "_flags"}, {28'd0, RFlags}, {28'd0, ef});
                    check({nm, "_zero"}, {31'd0, zero}, {31'd0, ef[0]});
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset      = 1'b1;
        data1      = '0;
        data2      = '0;
        ALUControl = 5'b00101;
        #3;
        check("reset_hold_result", ALUResult, 32'h0);
        check("reset_hold_flags", {28'd0, RFlags}, 32'h0);
        #2;
        reset = 1'b0;
        #2;
        check("post_reset_result", ALUResult, 32'h0);
        check("post_reset_flags", {28'd0, RFlags}, 32'h0);
        check("post_reset_zero", {31'd0, zero}, 32'h0);

        issue(5'b00101, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 4'b0010, "mov");
        issue(5'b00110, 32'h10,       32'h20,       32'h30,       4'b0000, "add");
        issue(5'b00111, 32'h30,       32'h20,       32'h10,       4'b0000, "sub");
        issue(5'b00110, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0110, "add_ovf");
`ifdef ALU32_MULDIV_EN
        issue(5'b01000, 32'h10,       32'h4,        32'h40,       4'b0000, "mul");
        issue(5'b01001, 32'h30,       32'h6,        32'h8,        4'b0000, "div");
        issue(5'b01000, 32'h10000,    32'h10000,    32'h0,        4'b0101, "mul_ovf");
        issue(5'b01000, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 4'b0010, "mul_neg");
        issue(5'b01001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0110, "div_ovf");
        issue(5'b01001, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b0010, "div_trunc");
`else
        issue(5'b01000, 32'h10,       32'h4,        32'h0,        4'b1000, "mul_disabled");
        issue(5'b01001, 32'h30,       32'h6,        32'h0,        4'b1000, "div_disabled");
`endif
        issue(5'b01010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        4'b0001, "and");
        issue(5'b01011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0010, "or");
        issue(5'b01100, 32'h10,       32'd5,        32'h200,      4'b0000, "shl5");
        issue(5'b01101, 32'h10,       32'd3,        32'h2,        4'b0000, "shr3");
        issue(5'b01100, 32'h10,       32'd40,       32'h0,        4'b0001, "shl40");
        issue(5'b01100, 32'h1,        32'd31,       32'h80000000, 4'b0010, "shl31");
        issue(5'b01101, 32'h80000000, 32'd31,       32'h1,        4'b0000, "shr31");
        issue(5'b01101, 32'hFFFFFFFF, 32'd32,       32'h0,        4'b0001, "shr32");
        issue(5'b00111, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0100, "sub_ovf");
        issue(5'b00101, 32'h1234,     32'h0,        32'h1234,     4'b0000, "mov_setup");
        issue(5'b01110, 32'h10,       32'h10,       32'h1234,     4'b0001, "cmp_eq");
        issue(5'b01110, 32'h5,        32'h10,       32'h1234,     4'b0010, "cmp_lt");
        issue(5'b01110, 32'h10,       32'h5,        32'h1234,     4'b0000, "cmp_gt");
        issue(5'b01001, 32'h30,       32'h0,        32'h0,        4'b1000, "div_by_zero");
        issue(5'b10101, 32'h30,       32'h6,        32'h0,        4'b1000, "bad_op");
        issue(5'b01110, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010, "cmp_signed");
        issue(5'b00000, 32'h1,        32'h1,        32'h0,        4'b1000, "bad_op0");

        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", q_res.size(), 32'd0);

        // Mid-stream reset: asynchronous clear, in-flight op discarded
        ALUControl = 5'b00101;
        data1      = 32'h5;
        data2      = 32'h0;
        @(posedge clk);
        #1;
        check("pre_reset_value", ALUResult, 32'h5);
        @(negedge clk);
        ALUControl = 5'b00110;
        data1      = 32'h1;
        data2      = 32'h2;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_result", ALUResult, 32'h0);
        check("async_reset_flags", {28'd0, RFlags}, 32'h0);
        @(posedge clk);
        #1;
        check("reset_ignores_inputs", ALUResult, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_op_after_reset", ALUResult, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu32_bits
`default_nettype wire
